// File: rtl/usb_hid_pkg.sv
// Shared definitions for the USB HID host blocks.
//   - state_t     : supervisor FSM encodings (S_OFF..S_FAULT)
//   - TYP_*       : device type codes reported by usb_hid_host on typ
//   - backoff_ms  : exponential backoff duration with shift and result saturation
package usb_hid_pkg;

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_PWR     = 3'd1,
        S_ENUM    = 3'd2,
        S_RUN     = 3'd3,
        S_BACKOFF = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    localparam logic [1:0] TYP_NONE  = 2'd0;
    localparam logic [1:0] TYP_KBD   = 2'd1;
    localparam logic [1:0] TYP_MOUSE = 2'd2;
    localparam logic [1:0] TYP_GAME  = 2'd3;

    // base << (cnt-1), shift capped at 6, result capped at 0xFFFF ms.
    // cnt is the failure count after the increment, so it is at least 1.
    function automatic logic [15:0] backoff_ms(input logic [15:0] base,
                                               input logic [2:0]  cnt);
        logic [2:0]  shift;
        logic [22:0] prod;
        shift = (cnt == 3'd0) ? 3'd0 : cnt - 3'd1;
        if (shift > 3'd6) shift = 3'd6;
        prod = {7'd0, base} << shift;
        return (prod[22:16] != 7'd0) ? 16'hFFFF : prod[15:0];
    endfunction

endpackage

// File: rtl/usb_ms_timer.sv
// Millisecond timer: cycle prescaler plus a saturating 16-bit ms counter.
// ms_count is the number of whole milliseconds completed counting the
// current cycle as one, so after a clear it reads N on the cycle that is
// N*CYCLES_PER_MS-1 cycles after the first cycle following the clear.
// A state that leaves when ms_count >= N therefore lasts exactly N ms.
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset (same as a clear)
//   clear     in   synchronous restart
//   ms_count  out  16-bit elapsed milliseconds, saturates at 0xFFFF
module usb_ms_timer #(
    parameter int CYCLES_PER_MS = 12000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    output logic [15:0] ms_count
);

    localparam int PW = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
    localparam logic [PW-1:0] PRESC_LAST  = PW'(CYCLES_PER_MS - 1);
    // The restart cycle itself already counts as one elapsed cycle.
    localparam logic [PW-1:0] PRESC_START = (CYCLES_PER_MS > 1) ? PW'(1) : PW'(0);
    localparam logic [15:0]   MS_START    = (CYCLES_PER_MS > 1) ? 16'd0 : 16'd1;

    logic [PW-1:0] presc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= PRESC_START;
            ms_count <= MS_START;
        end else if (clear) begin
            presc    <= PRESC_START;
            ms_count <= MS_START;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
            if (ms_count != 16'hFFFF) ms_count <= ms_count + 16'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

endmodule

// File: rtl/usb_hid_host_supervisor.sv
// Power and reset sequencer for one usb_hid_host instance.
// Powers the port, holds the host core in reset while VBUS settles, waits
// for enumeration, then watches conerr and report liveness. Failures
// power-cycle the port with exponential backoff; MAX_RETRIES consecutive
// failures latch S_FAULT.
// Ports:
//   usbclk       in   clock
//   usbrst_n     in   asynchronous active-low reset
//   enable       in   port enable; low forces S_OFF and clears retry_cnt
//   power_cycle  in   one-cycle request: restart the port or leave S_FAULT
//   host_typ     in   device type from usb_hid_host (0 = none)
//   host_conerr  in   connection error from usb_hid_host
//   host_report  in   report pulse from usb_hid_host
//   vbus_en      out  VBUS switch enable
//   host_rst_n   out  active-low reset to usb_hid_host
//   state        out  current FSM state (state_t encoding)
//   dev_ready    out  high only in S_RUN
//   fault        out  high only in S_FAULT
//   retry_cnt    out  consecutive failure count
// Control semantics: enable is a level and power_cycle a one-cycle pulse,
// both sampled on every clock edge with no acknowledge; enable low beats
// power_cycle, which beats any state-local event. A power_cycle pulse in
// S_OFF or S_BACKOFF is dropped, not queued.
module usb_hid_host_supervisor
    import usb_hid_pkg::*;
#(
    parameter int CLK_HZ            = 12000000,
    parameter int POWER_ON_MS       = 100,
    parameter int ENUM_TIMEOUT_MS   = 1000,
    parameter int CONERR_MASK_MS    = 20,
    parameter int REPORT_TIMEOUT_MS = 0,
    parameter int BACKOFF_BASE_MS   = 50,
    parameter int MAX_RETRIES       = 4
) (
    input  logic       usbclk,
    input  logic       usbrst_n,
    input  logic       enable,
    input  logic       power_cycle,
    input  logic [1:0] host_typ,
    input  logic       host_conerr,
    input  logic       host_report,
    output logic       vbus_en,
    output logic       host_rst_n,
    output logic [2:0] state,
    output logic       dev_ready,
    output logic       fault,
    output logic [2:0] retry_cnt
);

    localparam int          CYC_PER_MS   = CLK_HZ / 1000;
    localparam logic [15:0] POWER_ON     = 16'(POWER_ON_MS);
    localparam logic [15:0] ENUM_TIMEOUT = 16'(ENUM_TIMEOUT_MS);
    localparam logic [15:0] CONERR_MASK  = 16'(CONERR_MASK_MS);
    localparam logic [15:0] REPORT_TO    = 16'(REPORT_TIMEOUT_MS);
    localparam logic [15:0] BACKOFF_BASE = 16'(BACKOFF_BASE_MS);
    localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRIES);

    state_t      cur_state, next_state;
    logic [2:0]  retry_q, retry_next, retry_inc;
    logic [15:0] backoff_q, backoff_next;
    logic [15:0] state_ms, mask_ms, report_ms;
    logic        state_clear, mask_clear, report_clear;
    logic        fail_now;
    logic        conerr_fail, report_fail;

    // Time in the current state.
    assign state_clear = (next_state != cur_state);

    // Time since host reset release. Held clear until S_ENUM is entered
    // from S_PWR; an unplug (S_RUN -> S_ENUM) keeps it running.
    assign mask_clear = !(cur_state == S_ENUM || cur_state == S_RUN);

    // Time since the last report; idle outside S_RUN so S_RUN entry
    // starts a fresh window.
    assign report_clear = host_report || (cur_state != S_RUN);

    usb_ms_timer #(.CYCLES_PER_MS(CYC_PER_MS)) u_state_timer (
        .clk(usbclk), .rst_n(usbrst_n), .clear(state_clear), .ms_count(state_ms)
    );

    usb_ms_timer #(.CYCLES_PER_MS(CYC_PER_MS)) u_mask_timer (
        .clk(usbclk), .rst_n(usbrst_n), .clear(mask_clear), .ms_count(mask_ms)
    );

    usb_ms_timer #(.CYCLES_PER_MS(CYC_PER_MS)) u_report_timer (
        .clk(usbclk), .rst_n(usbrst_n), .clear(report_clear), .ms_count(report_ms)
    );

    assign retry_inc   = retry_q + 3'd1;
    assign conerr_fail = host_conerr && (mask_ms >= CONERR_MASK);
    assign report_fail = (REPORT_TO != 16'd0) && (report_ms >= REPORT_TO);

    always_comb begin
        next_state   = cur_state;
        retry_next   = retry_q;
        backoff_next = backoff_q;
        fail_now     = 1'b0;

        if (!enable) begin
            next_state = S_OFF;
            retry_next = 3'd0;
        end else if (power_cycle &&
                     (cur_state == S_PWR || cur_state == S_ENUM || cur_state == S_RUN)) begin
            next_state   = S_BACKOFF;
            backoff_next = BACKOFF_BASE;
        end else if (power_cycle && cur_state == S_FAULT) begin
            next_state = S_PWR;
            retry_next = 3'd0;
        end else begin
            case (cur_state)
                S_OFF:     next_state = S_PWR;
                S_PWR:     if (state_ms >= POWER_ON) next_state = S_ENUM;
                S_ENUM: begin
                    // Enumeration wins over a timeout on the same cycle.
                    if (host_typ != TYP_NONE) begin
                        next_state = S_RUN;
                        retry_next = 3'd0;
                    end else if (state_ms >= ENUM_TIMEOUT) begin
                        fail_now = 1'b1;
                    end
                end
                S_RUN: begin
                    // A failure wins over an unplug on the same cycle.
                    if (conerr_fail || report_fail) begin
                        fail_now = 1'b1;
                    end else if (host_typ == TYP_NONE) begin
                        next_state = S_ENUM;
                    end
                end
                S_BACKOFF: if (state_ms >= backoff_q) next_state = S_PWR;
                S_FAULT:   next_state = S_FAULT;
                default:   next_state = S_OFF;
            endcase

            if (fail_now) begin
                retry_next = retry_inc;
                if (({1'b0, retry_q} + 4'd1) >= RETRY_LIMIT) begin
                    next_state = S_FAULT;
                end else begin
                    next_state   = S_BACKOFF;
                    backoff_next = backoff_ms(BACKOFF_BASE, retry_inc);
                end
            end
        end
    end

    // Outputs are decoded from next_state so they change on the same edge
    // as the state; the async reset drops VBUS and host reset at once.
    always_ff @(posedge usbclk or negedge usbrst_n) begin
        if (!usbrst_n) begin
            cur_state  <= S_OFF;
            retry_q    <= 3'd0;
            backoff_q  <= BACKOFF_BASE;
            vbus_en    <= 1'b0;
            host_rst_n <= 1'b0;
            dev_ready  <= 1'b0;
            fault      <= 1'b0;
        end else begin
            cur_state  <= next_state;
            retry_q    <= retry_next;
            backoff_q  <= backoff_next;
            vbus_en    <= (next_state == S_PWR) || (next_state == S_ENUM) ||
                          (next_state == S_RUN);
            host_rst_n <= (next_state == S_ENUM) || (next_state == S_RUN);
            dev_ready  <= (next_state == S_RUN);
            fault      <= (next_state == S_FAULT);
        end
    end

    assign state     = cur_state;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_usb_hid_host_supervisor.sv
// Directed table-driven bench for usb_hid_host_supervisor.
// CLK_HZ=12000 (1 ms = 12 cycles), POWER_ON_MS=2, ENUM_TIMEOUT_MS=5,
// CONERR_MASK_MS=1, REPORT_TIMEOUT_MS=3, BACKOFF_BASE_MS=2, MAX_RETRIES=3.
// Each vector drives inputs on a falling edge, lets n rising edges pass,
// then compares all outputs on the next falling edge.
module tb_usb_hid_host_supervisor;

    localparam int CLK_HZ            = 12000;
    localparam int POWER_ON_MS       = 2;
    localparam int ENUM_TIMEOUT_MS   = 5;
    localparam int CONERR_MASK_MS    = 1;
    localparam int REPORT_TIMEOUT_MS = 3;
    localparam int BACKOFF_BASE_MS   = 2;
    localparam int MAX_RETRIES       = 3;

    // ---------------- clock / reset ----------------
    logic       usbclk = 1'b0;
    logic       usbrst_n;
    logic       enable, power_cycle, host_conerr, host_report;
    logic [1:0] host_typ;
    logic       vbus_en, host_rst_n, dev_ready, fault;
    logic [2:0] state, retry_cnt;

    always #5 usbclk = ~usbclk;

    usb_hid_host_supervisor #(
        .CLK_HZ(CLK_HZ), .POWER_ON_MS(POWER_ON_MS), .ENUM_TIMEOUT_MS(ENUM_TIMEOUT_MS),
        .CONERR_MASK_MS(CONERR_MASK_MS), .REPORT_TIMEOUT_MS(REPORT_TIMEOUT_MS),
        .BACKOFF_BASE_MS(BACKOFF_BASE_MS), .MAX_RETRIES(MAX_RETRIES)
    ) dut (
        .usbclk(usbclk), .usbrst_n(usbrst_n), .enable(enable), .power_cycle(power_cycle),
        .host_typ(host_typ), .host_conerr(host_conerr), .host_report(host_report),
        .vbus_en(vbus_en), .host_rst_n(host_rst_n), .state(state),
        .dev_ready(dev_ready), .fault(fault), .retry_cnt(retry_cnt)
    );

    // ---------------- vectors ----------------
    typedef struct packed {
        logic        en;
        logic        pc;
        logic [1:0]  typ;
        logic        ce;
        logic        rp;
        logic [15:0] n;
        logic [2:0]  st;
        logic        vb;
        logic        rs;
        logic [2:0]  rc;
    } vec_t;

    vec_t       vecs[$];
    logic [9:0] exp_q[$];
    int         n_vec = 0;
    int         n_bad = 0;

    function automatic vec_t mk(int en, int pc, int typ, int ce, int rp, int n,
                                int st, int vb, int rs, int rc);
        vec_t v;
        v.en = 1'(en);   v.pc = 1'(pc); v.typ = 2'(typ); v.ce = 1'(ce);
        v.rp = 1'(rp);   v.n  = 16'(n); v.st  = 3'(st);  v.vb = 1'(vb);
        v.rs = 1'(rs);   v.rc = 3'(rc);
        return v;
    endfunction

    // Expected word layout: {state, vbus_en, host_rst_n, dev_ready, fault, retry_cnt}
    function automatic logic [9:0] exp_word(logic [2:0] st, logic vb, logic rs, logic [2:0] rc);
        return {st, vb, rs, (st == 3'd3), (st == 3'd5), rc};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(vec_t v);
        enable      = v.en;
        power_cycle = v.pc;
        host_typ    = v.typ;
        host_conerr = v.ce;
        host_report = v.rp;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(string name);
        logic [9:0] got, want;
        got  = {state, vbus_en, host_rst_n, dev_ready, fault, retry_cnt};
        want = exp_q.pop_front();
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got state=%0d vbus=%b rst_n=%b rdy=%b flt=%b retry=%0d, want state=%0d vbus=%b rst_n=%b rdy=%b flt=%b retry=%0d",
                     name, got[9:7], got[6], got[5], got[4], got[3], got[2:0],
                     want[9:7], want[6], want[5], want[4], want[3], want[2:0]);
        end
    endtask

    task automatic apply(vec_t v, string name);
        drive(v);
        exp_q.push_back(exp_word(v.st, v.vb, v.rs, v.rc));
        repeat (int'(v.n)) @(posedge usbclk);
        @(negedge usbclk);
        check(name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "time limit");
    end

    initial begin
        // reset dominates a high enable
        usbrst_n = 1'b0;
        drive(mk(1,0,0,0,0, 0, 0,0,0,0));
        repeat (3) @(negedge usbclk);
        exp_q.push_back(exp_word(3'd0, 1'b0, 1'b0, 3'd0));
        check("reset_values");
        enable   = 1'b0;
        usbrst_n = 1'b1;
        @(negedge usbclk);

        // bring-up, conerr mask, backoff, unplug
        vecs.push_back(mk(1,0,0,0,0, 1, 1,1,0,0));
        vecs.push_back(mk(1,0,0,0,0,23, 1,1,0,0));
        vecs.push_back(mk(1,0,0,0,0, 1, 2,1,1,0));
        vecs.push_back(mk(1,0,0,0,0, 1, 2,1,1,0));
        vecs.push_back(mk(1,0,1,0,0, 1, 3,1,1,0));
        vecs.push_back(mk(1,0,1,0,0, 3, 3,1,1,0));
        vecs.push_back(mk(1,0,1,1,0, 1, 3,1,1,0));   // conerr 6 cycles after release: masked
        vecs.push_back(mk(1,0,1,0,0,13, 3,1,1,0));
        vecs.push_back(mk(1,0,1,1,0, 1, 4,0,0,1));   // conerr 20 cycles after release: failure
        vecs.push_back(mk(1,0,1,0,0,23, 4,0,0,1));
        vecs.push_back(mk(1,0,1,0,0, 1, 1,1,0,1));   // 24-cycle backoff
        vecs.push_back(mk(1,0,1,0,0,23, 1,1,0,1));
        vecs.push_back(mk(1,0,1,0,0, 1, 2,1,1,1));
        vecs.push_back(mk(1,0,1,0,0, 1, 3,1,1,0));   // enumeration clears retry_cnt
        vecs.push_back(mk(1,0,0,0,0, 1, 2,1,1,0));   // unplug: back to ENUM, power kept
        vecs.push_back(mk(1,0,1,0,0, 1, 3,1,1,0));
        vecs.push_back(mk(0,1,1,0,0, 1, 0,0,0,0));   // enable low beats power_cycle
        // never enumerates: timeouts, growing backoff, fault, exit by power_cycle
        vecs.push_back(mk(1,0,0,0,0, 1, 1,1,0,0));
        vecs.push_back(mk(1,0,0,0,0,23, 1,1,0,0));
        vecs.push_back(mk(1,0,0,0,0, 1, 2,1,1,0));
        vecs.push_back(mk(1,0,0,1,0,59, 2,1,1,0));   // conerr ignored in ENUM
        vecs.push_back(mk(1,0,0,0,0, 1, 4,0,0,1));
        vecs.push_back(mk(1,0,0,0,0,23, 4,0,0,1));
        vecs.push_back(mk(1,0,0,0,0, 1, 1,1,0,1));
        vecs.push_back(mk(1,0,0,0,0,23, 1,1,0,1));
        vecs.push_back(mk(1,0,0,0,0, 1, 2,1,1,1));
        vecs.push_back(mk(1,0,0,0,0,59, 2,1,1,1));
        vecs.push_back(mk(1,0,0,0,0, 1, 4,0,0,2));
        vecs.push_back(mk(1,0,0,0,0,47, 4,0,0,2));   // 48-cycle backoff
        vecs.push_back(mk(1,0,0,0,0, 1, 1,1,0,2));
        vecs.push_back(mk(1,0,0,0,0,23, 1,1,0,2));
        vecs.push_back(mk(1,0,0,0,0, 1, 2,1,1,2));
        vecs.push_back(mk(1,0,0,0,0,59, 2,1,1,2));
        vecs.push_back(mk(1,0,0,0,0, 1, 5,0,0,3));
        vecs.push_back(mk(1,0,0,0,0,30, 5,0,0,3));   // fault is sticky
        vecs.push_back(mk(1,1,0,0,0, 1, 1,1,0,0));
        vecs.push_back(mk(1,0,0,0,0, 1, 1,1,0,0));
        // power_cycle from PWR, ignored in BACKOFF
        vecs.push_back(mk(1,1,0,0,0, 1, 4,0,0,0));
        vecs.push_back(mk(1,1,0,0,0, 1, 4,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,22, 4,0,0,0));
        vecs.push_back(mk(1,0,0,0,0, 1, 1,1,0,0));
        vecs.push_back(mk(0,0,0,0,0, 1, 0,0,0,0));
        // typ arrives on the timeout cycle: RUN wins
        vecs.push_back(mk(1,0,0,0,0, 1, 1,1,0,0));
        vecs.push_back(mk(1,0,0,0,0,23, 1,1,0,0));
        vecs.push_back(mk(1,0,0,0,0, 1, 2,1,1,0));
        vecs.push_back(mk(1,0,0,0,0,59, 2,1,1,0));
        vecs.push_back(mk(1,0,1,0,0, 1, 3,1,1,0));
        // unplug and conerr together: failure wins
        vecs.push_back(mk(1,0,0,1,0, 1, 4,0,0,1));
        vecs.push_back(mk(1,0,0,0,0,23, 4,0,0,1));
        vecs.push_back(mk(1,0,0,0,0, 1, 1,1,0,1));
        vecs.push_back(mk(0,0,0,0,0, 1, 0,0,0,0));   // enable low clears retry_cnt

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // report watchdog: pulses every 30 cycles keep RUN
        apply(mk(1,0,1,0,0, 1, 1,1,0,0), "wd_pwr");
        apply(mk(1,0,1,0,0,24, 2,1,1,0), "wd_enum");
        apply(mk(1,0,1,0,0, 1, 3,1,1,0), "wd_run");
        for (int r = 0; r < 3; r++) begin
            apply(mk(1,0,1,0,1, 1, 3,1,1,0), $sformatf("wd_pulse%0d", r));
            apply(mk(1,0,1,0,0,29, 3,1,1,0), $sformatf("wd_gap%0d", r));
        end
        // reports stop: still RUN 35 cycles after the last pulse, BACKOFF at 36
        apply(mk(1,0,1,0,1, 1, 3,1,1,0), "wd_last_pulse");
        apply(mk(1,0,1,0,0,35, 3,1,1,0), "wd_edge_minus1");
        apply(mk(1,0,1,0,0, 1, 4,0,0,1), "wd_expire");

        // async reset mid-RUN drops power before the next clock edge
        apply(mk(0,0,1,0,0, 1, 0,0,0,0), "rst_off");
        apply(mk(1,0,1,0,0, 1, 1,1,0,0), "rst_pwr");
        apply(mk(1,0,1,0,0,24, 2,1,1,0), "rst_enum");
        apply(mk(1,0,1,0,0, 1, 3,1,1,0), "rst_run");
        usbrst_n = 1'b0;
        #1;
        exp_q.push_back(exp_word(3'd0, 1'b0, 1'b0, 3'd0));
        check("async_reset");
        @(negedge usbclk);
        usbrst_n = 1'b1;
        apply(mk(1,0,1,0,0, 1, 1,1,0,0), "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/usb_hid_host_supervisor.md
Name: usb_hid_host_supervisor

Overview:
Power and reset sequencer for one usb_hid_host instance. Drives the port's VBUS enable and the host core's active-low reset, and waits for enumeration (typ != 0). In operation it watches conerr and report liveness, and on failure power-cycles the port with exponential backoff. After repeated failures it latches a fault so the system reports a dead port instead of retrying forever.

Parameters:
CLK_HZ, 12000000, usbclk frequency; 1 ms = CLK_HZ/1000 cycles
POWER_ON_MS, 100, VBUS-on settle time before host reset is released
ENUM_TIMEOUT_MS, 1000, maximum wait for typ != 0 after reset release
CONERR_MASK_MS, 20, window after reset release during which host_conerr is ignored
REPORT_TIMEOUT_MS, 0, maximum gap between host_report pulses in S_RUN; 0 disables the check
BACKOFF_BASE_MS, 50, first backoff duration; doubles per retry
MAX_RETRIES, 4, consecutive failures before S_FAULT (1..7)

Ports:
usbclk  in  1  12 MHz clock
usbrst_n  in  1  asynchronous active-low reset
enable  in  1  port enable; low forces S_OFF
power_cycle  in  1  single-cycle request to power-cycle the port or leave S_FAULT
host_typ  in  2  typ from usb_hid_host (0 = no device)
host_conerr  in  1  conerr from usb_hid_host
host_report  in  1  report pulse from usb_hid_host
vbus_en  out  1  port VBUS switch enable
host_rst_n  out  1  to usb_hid_host usbrst_n
state  out  3  current FSM state
dev_ready  out  1  high only in S_RUN
fault  out  1  high only in S_FAULT
retry_cnt  out  3  consecutive failure count

Behaviour:
- Reset values: vbus_en=0, host_rst_n=0, state=S_OFF, dev_ready=0, fault=0, retry_cnt=0. All outputs are registered.
- States: S_OFF=0, S_PWR=1, S_ENUM=2, S_RUN=3, S_BACKOFF=4, S_FAULT=5.
- Per-state outputs:
  - S_OFF, S_BACKOFF, S_FAULT: vbus_en=0, host_rst_n=0.
  - S_PWR: vbus_en=1, host_rst_n=0.
  - S_ENUM, S_RUN: vbus_en=1, host_rst_n=1.
- Timer: the cycle prescaler and the ms counter (16 bits) clear on every state change. "N ms elapsed" means N*CLK_HZ/1000 cycles since the entry cycle. The transition happens on that cycle and takes effect on the next edge.
- Priority, highest first: ~enable, then power_cycle, then state-local events.
- ~enable in any state -> S_OFF and retry_cnt=0. In S_OFF, enable=1 -> S_PWR.
- S_PWR: POWER_ON_MS elapsed -> S_ENUM.
- S_ENUM:
  - host_typ != 0 -> S_RUN and retry_cnt=0.
  - ENUM_TIMEOUT_MS elapsed -> failure.
  - If typ becomes nonzero on the timeout cycle, S_RUN wins.
- S_RUN:
  - host_typ == 0 (device unplugged) -> S_ENUM with the timer restarted and no power cycle.
  - host_conerr=1 after CONERR_MASK_MS since reset release -> failure. The mask runs from S_ENUM entry and carries into S_RUN; it is not restarted.
  - REPORT_TIMEOUT_MS != 0 and no host_report for that long -> failure. Each host_report pulse restarts the report timer.
  - If typ==0 and a failure occur on the same cycle, the failure wins.
- Failure handling:
  - If retry_cnt+1 == MAX_RETRIES: retry_cnt increments and the FSM goes to S_FAULT.
  - Otherwise: retry_cnt increments and the FSM goes to S_BACKOFF.
- S_BACKOFF:
  - Duration = BACKOFF_BASE_MS << (retry_cnt-1), where retry_cnt is the value after the increment.
  - The shift saturates at 6; the 16-bit product saturates at 0xFFFF.
  - When the duration elapses -> S_PWR.
- power_cycle:
  - In S_PWR, S_ENUM or S_RUN -> S_BACKOFF for BACKOFF_BASE_MS, retry_cnt unchanged.
  - In S_FAULT -> retry_cnt=0, then S_PWR.
  - Ignored in S_OFF and S_BACKOFF.
- S_FAULT is sticky until power_cycle or ~enable.
- host_conerr is ignored outside S_RUN, because the core asserts it while held in reset.
- Asynchronous reset mid-operation drops vbus_en and host_rst_n immediately, without waiting for a clock edge.

Decomposition:
- Shared package usb_hid_pkg holds:
  - state encodings S_OFF..S_FAULT;
  - typ codes: TYP_NONE=0, TYP_KBD=1, TYP_MOUSE=2, TYP_GAME=3.
- One sub-module, usb_ms_timer: prescaler plus 16-bit ms counter with synchronous clear input and ms_count output. It is reusable by other blocks in the host.

Test Plan (all scenarios use CLK_HZ=12000, so 1 ms = 12 cycles; POWER_ON_MS=2, ENUM_TIMEOUT_MS=5, CONERR_MASK_MS=1, BACKOFF_BASE_MS=2, MAX_RETRIES=3):
1. Normal bring-up: enable=1, and host_typ=1 two cycles after host_rst_n rises -> vbus_en=1 at cycle 1; host_rst_n=1 24 cycles later; dev_ready=1; retry_cnt=0.
2. Never enumerates: host_typ=0 throughout -> three ENUM timeouts, with backoffs of 24 and 48 cycles at vbus_en=0 between them. After the third timeout: state=5, fault=1, retry_cnt=3. Then a power_cycle pulse -> state=1, retry_cnt=0.
3. conerr in S_RUN: host_conerr=1 at 6 cycles after reset release is ignored (inside mask). host_conerr=1 at 20 cycles -> state=4, retry_cnt=1, vbus_en=0 on the next edge.
4. Unplug: host_typ goes 1->0 in S_RUN -> state=2, vbus_en stays 1, host_rst_n stays 1, retry_cnt unchanged.
5. Report watchdog with REPORT_TIMEOUT_MS=3: a report every 30 cycles keeps S_RUN; stopping reports -> S_BACKOFF exactly 36 cycles after the last pulse.
6. Priorities: enable=0 on the same cycle as power_cycle in S_RUN -> S_OFF, retry_cnt=0. Asserting usbrst_n low mid-S_RUN -> vbus_en=0 before the next clock edge.
